// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// memory, execute and writeback, with a mem_ready watchdog and illegal-op detection.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal_instr,
    output logic       fault,
    output logic [3:0] state
);

    localparam int unsigned ST_W = 4;

    localparam logic [ST_W-1:0] S_FETCH    = 4'd0;
    localparam logic [ST_W-1:0] S_DECODE   = 4'd1;
    localparam logic [ST_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [ST_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [ST_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [ST_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [ST_W-1:0] S_EXECUTER = 4'd6;
    localparam logic [ST_W-1:0] S_EXECUTEI = 4'd7;
    localparam logic [ST_W-1:0] S_ALUWB    = 4'd8;
    localparam logic [ST_W-1:0] S_BEQ      = 4'd9;
    localparam logic [ST_W-1:0] S_JAL      = 4'd10;
    localparam logic [ST_W-1:0] S_ILLEGAL  = 4'd11;
    localparam logic [ST_W-1:0] S_FAULT    = 4'd12;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Counter only needs to hold MEM_TIMEOUT-1; reaching that with no ready faults.
    localparam int unsigned CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned CNT_MAX = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CNT_MAX);
    localparam logic WDOG_EN = (MEM_TIMEOUT != 0);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       wait_st;
    logic       timeout;
    logic       pc_update;
    logic       branch;
    logic       mem_req_c;
    logic       adr_src_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] result_src_c;
    logic       illegal_c;
    logic       fault_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, watchdog and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        wait_st      = 1'b0;
        timeout      = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        mem_req_c    = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;
        illegal_c    = 1'b0;
        fault_c      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c    = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = mem_ready;
                pc_update    = mem_ready;
                wait_st      = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                wait_st   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                wait_st     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                branch      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_update   = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                state_d   = S_FETCH;
            end
            S_FAULT: begin
                fault_c = 1'b1;
                state_d = S_FAULT;
            end
            default: state_d = S_FETCH;
        endcase

        // A ready arriving on the limit cycle takes the normal transition.
        timeout = WDOG_EN && wait_st && !mem_ready && (cnt_q == CNT_LIM);
        if (timeout) begin
            state_d    = S_FAULT;
            ir_write_c = 1'b0;
            pc_update  = 1'b0;
        end

        if (WDOG_EN && wait_st && !mem_ready && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pc_write_c = pc_update | (branch & zero);
    end

    // Reset forces every strobe and select low immediately, independent of the clock.
    assign mem_req       = rst_n & mem_req_c;
    assign adr_src       = rst_n & adr_src_c;
    assign mem_write     = rst_n & mem_write_c;
    assign ir_write      = rst_n & ir_write_c;
    assign pc_write      = rst_n & pc_write_c;
    assign reg_write     = rst_n & reg_write_c;
    assign alu_src_a     = rst_n ? alu_src_a_c  : 2'b00;
    assign alu_src_b     = rst_n ? alu_src_b_c  : 2'b00;
    assign alu_op        = rst_n ? alu_op_c     : 2'b00;
    assign result_src    = rst_n ? result_src_c : 2'b00;
    assign illegal_instr = rst_n & illegal_c;
    assign fault         = rst_n & fault_c;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed vector table, hand-written timeout/reset
// sequence, then random instruction streams against an instruction-path model.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned TO = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       illegal_instr, fault;
    logic [3:0] state;
    logic [15:0] dut_b;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .illegal_instr(illegal_instr), .fault(fault),
        .state(state)
    );

    assign dut_b = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] out;
    } vec_t;

    vec_t tv[$];

    function automatic logic [15:0] pk(input logic mr, input logic ad, input logic mw,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic [1:0] rs,
                                       input logic ill, input logic flt);
        return {mr, ad, mw, irw, pcw, rw, a, b, aop, rs, ill, flt};
    endfunction

    task automatic add_vec(input logic [6:0] o, input logic z, input logic r,
                           input logic [3:0] st, input logic [15:0] out);
        vec_t v;
        v.op = o; v.zero = z; v.rdy = r; v.st = st; v.out = out;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] est, input logic [15:0] eout);
        total++;
        if (state !== est) begin
            bad++;
            $display("FAIL %s state got=%0d want=%0d", nm, state, est);
        end
        total++;
        if (dut_b !== eout) begin
            bad++;
            $display("FAIL %s outputs got=%h want=%h", nm, dut_b, eout);
        end
    endtask

    // Expected outputs for a spec state given the live inputs.
    function automatic logic [15:0] spec_out(input int s, input logic r, input logic z);
        case (s)
            0:  return pk(1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
            1:  return pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
            2:  return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
            3:  return pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
            4:  return pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
            5:  return pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
            6:  return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
            7:  return pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0);
            8:  return pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
            9:  return pk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0);
            10: return pk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
            11: return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
            default: return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
        endcase
    endfunction

    // Model: each instruction is a list of states it visits; memory states repeat while stalled.
    int         path[$];
    int         idx;
    int         wcnt;
    bit         faulted;
    int         fcyc;
    logic [6:0] cur_op;

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 7))
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_R;
            3: return OP_I;
            4: return OP_BEQ;
            5: return OP_JAL;
            6: return OP_BAD;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic new_instr();
        cur_op = pick_op();
        path.delete();
        path.push_back(0);
        path.push_back(1);
        if (cur_op == OP_LW)       begin path.push_back(2); path.push_back(3); path.push_back(4); end
        else if (cur_op == OP_SW)  begin path.push_back(2); path.push_back(5); end
        else if (cur_op == OP_R)   begin path.push_back(6); path.push_back(8); end
        else if (cur_op == OP_I)   begin path.push_back(7); path.push_back(8); end
        else if (cur_op == OP_BEQ) path.push_back(9);
        else if (cur_op == OP_JAL) begin path.push_back(10); path.push_back(8); end
        else                       path.push_back(11);
        idx  = 0;
        wcnt = 0;
    endtask

    task automatic model_reset();
        faulted = 1'b0;
        fcyc    = 0;
        new_instr();
    endtask

    function automatic int model_state();
        return faulted ? 12 : path[idx];
    endfunction

    task automatic model_step(input logic r);
        int s;
        if (faulted) begin
            fcyc++;
        end else begin
            s = path[idx];
            if ((s == 0 || s == 3 || s == 5) && !r) begin
                wcnt++;
                if (wcnt == TO) faulted = 1'b1;
            end else begin
                wcnt = 0;
                idx++;
                if (idx == path.size()) new_instr();
            end
        end
    endtask

    logic [15:0] o_fetch_r, o_fetch_w, o_dec, o_madr, o_mrd, o_mwb, o_exr;
    logic [15:0] o_aluwb, o_beq1, o_beq0, o_jal, o_ill, o_mwr, o_flt;

    initial begin
        o_fetch_r = pk(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
        o_fetch_w = pk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
        o_dec     = pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0);
        o_madr    = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0);
        o_mrd     = pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        o_mwb     = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0);
        o_exr     = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
        o_aluwb   = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        o_beq1    = pk(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0);
        o_beq0    = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0);
        o_jal     = pk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0);
        o_ill     = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        o_mwr     = pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
        o_flt     = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

        // add
        add_vec(OP_R, 0, 1, 0, o_fetch_r);
        add_vec(OP_R, 0, 1, 1, o_dec);
        add_vec(OP_R, 0, 1, 6, o_exr);
        add_vec(OP_R, 0, 1, 8, o_aluwb);
        // lw with three stall cycles; ready on the watchdog limit cycle
        add_vec(OP_LW, 0, 1, 0, o_fetch_r);
        add_vec(OP_LW, 0, 1, 1, o_dec);
        add_vec(OP_LW, 0, 1, 2, o_madr);
        add_vec(OP_LW, 0, 0, 3, o_mrd);
        add_vec(OP_LW, 0, 0, 3, o_mrd);
        add_vec(OP_LW, 0, 0, 3, o_mrd);
        add_vec(OP_LW, 0, 1, 3, o_mrd);
        add_vec(OP_LW, 0, 1, 4, o_mwb);
        // beq taken / not taken
        add_vec(OP_BEQ, 1, 1, 0, o_fetch_r);
        add_vec(OP_BEQ, 1, 1, 1, o_dec);
        add_vec(OP_BEQ, 1, 1, 9, o_beq1);
        add_vec(OP_BEQ, 0, 1, 0, o_fetch_r);
        add_vec(OP_BEQ, 0, 1, 1, o_dec);
        add_vec(OP_BEQ, 0, 1, 9, o_beq0);
        // jal
        add_vec(OP_JAL, 0, 1, 0, o_fetch_r);
        add_vec(OP_JAL, 0, 1, 1, o_dec);
        add_vec(OP_JAL, 0, 1, 10, o_jal);
        add_vec(OP_JAL, 0, 1, 8, o_aluwb);
        // illegal opcode
        add_vec(OP_BAD, 0, 1, 0, o_fetch_r);
        add_vec(OP_BAD, 0, 1, 1, o_dec);
        add_vec(OP_BAD, 0, 1, 11, o_ill);
        add_vec(OP_BAD, 0, 0, 0, o_fetch_w);

        rst_n     = 1'b0;
        op        = OP_R;
        zero      = 1'b1;
        mem_ready = 1'b1;
        #2;
        chk("reset", 4'd0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            op        = tv[i].op;
            zero      = tv[i].zero;
            mem_ready = tv[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), tv[i].st, tv[i].out);
            @(negedge clk);
        end

        // sw that never completes: watchdog fault, then async reset
        op = OP_SW; zero = 1'b0; mem_ready = 1'b1;
        #1; chk("sw_fetch", 4'd0, o_fetch_r); @(negedge clk);
        mem_ready = 1'b0;
        #1; chk("sw_decode", 4'd1, o_dec); @(negedge clk);
        #1; chk("sw_memadr", 4'd2, o_madr); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1; chk($sformatf("sw_wait%0d", i), 4'd5, o_mwr); @(negedge clk);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk($sformatf("fault_hold%0d", i), 4'd12, o_flt); @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1 chk("fault_async_reset", 4'd0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // random instruction stream
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            op        = cur_op;
            zero      = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk($sformatf("rnd%0d", c), 4'(model_state()),
                spec_out(model_state(), mem_ready, zero));
            model_step(mem_ready);
            if (faulted && fcyc >= 3) begin
                #1 rst_n = 1'b0;
                #1 chk($sformatf("rnd_reset%0d", c), 4'd0, 16'h0000);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end else begin
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine for the multicycle RV32I core variant. It sequences the shared ALU, register file, instruction register, PC and unified memory port over several cycles per instruction. It drives the 2-bit alu_op into the existing ALU decoder (00 add, 01 subtract, 10 funct-decoded). It waits on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 16, maximum cycles waiting for mem_ready in any memory state before fault; 0 disables the watchdog.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
op  input  7  instr[6:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory accepts a write or returns read data this cycle
mem_req  output  1  memory access active
adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register and OldPC load enable
pc_write  output  1  PC load enable
reg_write  output  1  register file write enable
alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
alu_src_b  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
alu_op  output  2  to ALU decoder: 00 add, 01 subtract, 10 funct-decoded
result_src  output  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result
illegal_instr  output  1  one-cycle pulse for an unsupported opcode
fault  output  1  sticky memory-timeout flag
state  output  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, ILLEGAL 11, FAULT 12.
- Reset: asynchronous entry to FETCH; timeout counter cleared. While rst_n=0, all enables (mem_req, mem_write, ir_write, pc_write, reg_write) are 0, illegal_instr=0, fault=0, and state=0. All selects are 0 during reset.
- Outputs are a combinational decode of state; any signal not listed for a state is 0.
- pc_write = pc_update | (branch & zero), where pc_update and branch are internal signals.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_update equal mem_ready. Go to DECODE on mem_ready; otherwise hold.
- DECODE: a=01, b=01, alu_op=00 (branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> ILLEGAL
- MEMADR: a=10, b=01, alu_op=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1, result_src=00. Hold until mem_ready, then FETCH. mem_write stays high through the wait.
- EXECUTER: a=10, b=00, alu_op=10, then ALUWB.
- EXECUTEI: a=10, b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1, then ALUWB (writes rd = PC+4).
- ILLEGAL: illegal_instr=1 for exactly one cycle, no writes, then FETCH. The PC was already advanced, so the instruction is skipped.
- Watchdog, MEM_TIMEOUT>0 only:
  - The counter increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - It clears on mem_ready=1 or on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT.
  - mem_ready=1 in the same cycle the count reaches the limit wins: the normal transition is taken and there is no fault.
- FAULT: terminal; fault=1, all enables 0, exit only by reset.
- Reset mid-instruction: abandons the instruction with no partial writes after rst_n falls, and restarts at FETCH.

Test Plan:
- add (op=0110011), mem_ready=1 in FETCH -> states 0,1,6,8,0. reg_write=1 only in ALUWB; alu_op=10 in EXECUTER; 4 cycles total.
- lw with mem_ready held low 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles with adr_src=1, then MEMWB with result_src=01 and reg_write=1; 5 states plus 3 wait cycles.
- beq with zero=1 -> pc_write=1 in BEQ with alu_op=01. Repeat with zero=0 -> pc_write=0 in BEQ.
- jal -> pc_write=1 in JAL, then ALUWB with reg_write=1, then FETCH.
- op=1111111 -> ILLEGAL for exactly 1 cycle with illegal_instr=1 and no write enables, then FETCH.
- MEM_TIMEOUT=4, sw with mem_ready never high -> FAULT after 4 wait cycles with fault=1 held. Assert rst_n=0 -> state=0, fault=0 immediately, without waiting for a clock edge.
